// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N demultiplexer.
package demux_pkg;

    localparam int DEF_DATA_W = 1;
    localparam int DEF_N_OUT  = 4;

    // Upper bound on lanes handled by the select decoder.
    localparam int MAX_LANES  = 64;

    // Select width for n_out lanes; never narrower than one bit.
    function automatic int calc_sel_w(input int n_out);
        return (n_out <= 2) ? 1 : $clog2(n_out);
    endfunction

    // One-hot lane mask for a select value. Out-of-range selects give an
    // all-zero mask. A select with unknown bits never compares equal, so
    // it also gives all zeros in simulation.
    function automatic logic [MAX_LANES-1:0] sel_to_onehot(
        input logic [31:0] sel,
        input int          n_out
    );
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if ((k < n_out) && (sel == 32'(k))) begin
                mask[k] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: passes the input through when enabled, otherwise zero.
module demux_lane
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] lane_in,
    input  logic              lane_en,
    output logic [DATA_W-1:0] lane_out
);

    // Gate the shared input with this lane's enable.
    always_comb begin
        lane_out = lane_in & {DATA_W{lane_en}};
    end

endmodule

// File: rtl/demux_1to4.sv
// 1-to-N demultiplexer with combinational outputs and a one-cycle
// registered copy. Non-selected lanes are zero; an out-of-range select
// zeroes every lane and raises sel_err.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SEL_W  = calc_sel_w(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       demux_in,
    input  logic [SEL_W-1:0]        demux_select,
    output logic [N_OUT*DATA_W-1:0] demux_out,
    output logic [N_OUT*DATA_W-1:0] demux_out_q,
    output logic                    sel_err
);

    logic [N_OUT-1:0]        lane_en;
    logic [N_OUT*DATA_W-1:0] out_p0;
    logic [N_OUT*DATA_W-1:0] out_p1;

    // Decode the select into a one-hot lane enable; empty mask means illegal.
    always_comb begin
        lane_en = N_OUT'(sel_to_onehot(32'(demux_select), N_OUT));
        sel_err = ~|lane_en;
    end

    // Stage p0: combinational lane gating.
    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        demux_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .lane_in  (demux_in),
            .lane_en  (lane_en[k]),
            .lane_out (out_p0[k*DATA_W +: DATA_W])
        );
    end

    assign demux_out = out_p0;

    // Stage p1: registered copy, cleared while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= '0;
        end else begin
            out_p1 <= out_p0;
        end
    end

    assign demux_out_q = out_p1;

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4 across three parameter sets.
module tb_demux_1to4;

    logic clk;
    logic rst;

    // Defaults: DATA_W=1, N_OUT=4
    logic [0:0]  in_a;
    logic [1:0]  sel_a;
    logic [3:0]  out_a, outq_a;
    logic        err_a;

    // DATA_W=8, N_OUT=3 (non power of two)
    logic [7:0]  in_b;
    logic [1:0]  sel_b;
    logic [23:0] out_b, outq_b;
    logic        err_b;

    // DATA_W=4, N_OUT=8
    logic [3:0]  in_c;
    logic [2:0]  sel_c;
    logic [31:0] out_c, outq_c;
    logic        err_c;

    int n_tests;
    int n_fail;

    demux_1to4 u_def (
        .clk          (clk),
        .rst          (rst),
        .demux_in     (in_a),
        .demux_select (sel_a),
        .demux_out    (out_a),
        .demux_out_q  (outq_a),
        .sel_err      (err_a)
    );

    demux_1to4 #(.DATA_W(8), .N_OUT(3)) u_n3 (
        .clk          (clk),
        .rst          (rst),
        .demux_in     (in_b),
        .demux_select (sel_b),
        .demux_out    (out_b),
        .demux_out_q  (outq_b),
        .sel_err      (err_b)
    );

    demux_1to4 #(.DATA_W(4), .N_OUT(8)) u_n8 (
        .clk          (clk),
        .rst          (rst),
        .demux_in     (in_c),
        .demux_select (sel_c),
        .demux_out    (out_c),
        .demux_out_q  (outq_c),
        .sel_err      (err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: data shifted into lane sel, or zero when sel is out of range.
    function automatic logic [63:0] ref_out(input int unsigned din, input int unsigned sel,
                                            input int unsigned dw, input int unsigned n);
        if (sel >= n) return 64'd0;
        return 64'(din) << (sel * dw);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_b, exp_c;
        n_tests = 0;
        n_fail  = 0;
        in_a = '0; sel_a = '0;
        in_b = '0; sel_b = '0;
        in_c = '0; sel_c = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_q_a", 64'(outq_a), 64'd0);
        check("rst_q_b", 64'(outq_b), 64'd0);
        check("rst_q_c", 64'(outq_c), 64'd0);
        rst = 1'b0;

        // One-hot routing of a 1, and all-zero routing of a 0
        for (int d = 1; d >= 0; d--) begin
            in_a = 1'(d);
            for (int s = 0; s < 4; s++) begin
                sel_a = 2'(s);
                #1;
                check("route_a", 64'(out_a), ref_out(d, s, 1, 4));
                check("err_a", 64'(err_a), 64'd0);
            end
        end

        // Activity, then reset for two cycles
        in_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_a = 2'($urandom_range(3));
            tick();
        end
        rst = 1'b1;
        tick();
        check("rst1_q_a", 64'(outq_a), 64'd0);
        tick();
        check("rst2_q_a", 64'(outq_a), 64'd0);
        rst   = 1'b0;
        sel_a = 2'd2;
        in_a  = 1'b1;
        #1;
        check("rel_pre_q", 64'(outq_a), 64'd0);
        check("rel_comb", 64'(out_a), 64'h4);
        tick();
        check("rel_post_q", 64'(outq_a), 64'h4);

        // Registered latency: select 3 -> 1 between edges
        sel_a = 2'd3;
        tick();
        check("lat_q3", 64'(outq_a), 64'h8);
        sel_a = 2'd1;
        #1;
        check("lat_comb1", 64'(out_a), 64'h2);
        check("lat_hold_q", 64'(outq_a), 64'h8);
        tick();
        check("lat_q1", 64'(outq_a), 64'h2);

        // N_OUT=3 boundary: sel 3 is illegal
        in_b = 8'hA5;
        for (int s = 0; s < 4; s++) begin
            sel_b = 2'(s);
            #1;
            check("n3_out", 64'(out_b), ref_out(32'hA5, s, 8, 3));
            check("n3_err", 64'(err_b), (s >= 3) ? 64'd1 : 64'd0);
        end

        // Random traffic on the wide and non-power-of-two instances
        for (int i = 0; i < 1000; i++) begin
            in_c  = 4'($urandom);
            sel_c = 3'($urandom);
            in_b  = 8'($urandom);
            sel_b = 2'($urandom);
            exp_c = ref_out(in_c, sel_c, 4, 8);
            exp_b = ref_out(in_b, sel_b, 8, 3);
            #1;
            check("rnd_out_c", 64'(out_c), exp_c);
            check("rnd_err_c", 64'(err_c), 64'd0);
            check("rnd_out_b", 64'(out_b), exp_b);
            check("rnd_err_b", 64'(err_b), (sel_b == 2'd3) ? 64'd1 : 64'd0);
            tick();
            check("rnd_q_c", 64'(outq_c), exp_c);
            check("rnd_q_b", 64'(outq_b), exp_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to4.md
# demux_1to4

Parameterised 1-to-N demultiplexer (default 1-bit data, 4 outputs) that routes a single input to the output lane chosen by a binary select. All non-selected lanes drive zero. It provides a zero-latency combinational output and a one-cycle registered copy, so downstream logic can pick either timing. It is a leaf block used wherever one source must be steered to one of several sinks.

## Interface
Parameters:
- DATA_W, default 1: width of each data lane.
- N_OUT, default 4: number of output lanes; must be at least 2.
- SEL_W, default $clog2(N_OUT): select width; derived, not overridden.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- demux_in  input  DATA_W  data to route.
- demux_select  input  SEL_W  binary index of the destination lane.
- demux_out  output  N_OUT*DATA_W  combinational outputs; lane k is bits [k*DATA_W +: DATA_W].
- demux_out_q  output  N_OUT*DATA_W  registered copy of demux_out.
- sel_err  output  1  combinational; high when demux_select ≥ N_OUT.

## Operation
- Lane k of demux_out = demux_in when demux_select == k; otherwise lane k = 0.
- Exactly one lane carries demux_in for a legal select. If demux_in is 0, all outputs are zero.
- Select ≥ N_OUT (possible only when N_OUT is not a power of two): all lanes are 0 and sel_err = 1.
- Select containing X/Z is treated as illegal: all lanes are 0. sel_err follows the same rule only in simulation; synthesis has no X.
- With defaults, demux_in = 1 gives:
  - sel 0 → 0001
  - sel 1 → 0010
  - sel 2 → 0100
  - sel 3 → 1000
- demux_out_q loads demux_out on every rising clk edge when rst = 0.
- There is no enable or handshake; the block is always active.

## Timing
- demux_out and sel_err are purely combinational. Latency is zero, and they react within the same delta as any input change, independent of clk and rst.
- demux_out_q has one-cycle latency: the value present before edge n appears after edge n.
- Reset: while rst = 1 at a rising edge, demux_out_q becomes all zeros. demux_out is unaffected by reset.
- Reset takes priority over the load. If rst is asserted mid-stream, the next edge clears demux_out_q, and the first edge with rst = 0 loads the current demux_out.
- Simultaneous select and data change: demux_out_q captures the combined value settled before the edge.
- demux_out_q is undefined from power-up until the first reset edge; the system must assert rst for at least one cycle.

## Structure
- Shared package demux_pkg holds:
  - the default DATA_W and N_OUT constants;
  - a function computing SEL_W;
  - a function mapping a select value to a one-hot lane mask of N_OUT bits (all zero when out of range).
- One natural sub-module, demux_lane: a single-lane AND of demux_in with its one-hot enable, instantiated N_OUT times with a generate loop.
- The output register is in the top level; do not split it out.

## Test plan
- Defaults, demux_in = 1, select stepped 0, 1, 2, 3 → demux_out = 0001, 0010, 0100, 1000; sel_err = 0 throughout.
- Defaults, demux_in = 0, all four selects → demux_out = 0000 every time.
- rst = 1 for 2 cycles after arbitrary activity → demux_out_q = 0000. Release rst with sel = 2, demux_in = 1 → 0100 after the next edge, and not before.
- Registered latency check: change select 3 → 1 between edges → demux_out updates immediately; demux_out_q shows 1000 until the edge, then 0010.
- N_OUT = 3, DATA_W = 8, demux_in = 8'hA5, sel = 3 → all lanes 0 and sel_err = 1. sel = 1 → lane 1 = A5, other lanes 00, sel_err = 0.
- DATA_W = 4, N_OUT = 8, random in/sel for 1000 cycles → demux_out matches the reference model every cycle, and demux_out_q equals the previous cycle's demux_out.
